// File: rtl/prim_debounce_filter_pkg.sv
// prim_debounce_filter_pkg: shared types and helpers for the debounce filter.
package prim_debounce_filter_pkg;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;

  function automatic edge_t edge_detect(logic prev, logic next);
    return '{rise: next & ~prev, fall: prev & ~next};
  endfunction

endpackage

// File: rtl/prim_flop_sync_chain.sv
// prim_flop_sync_chain: plain flop chain resynchronising an asynchronous input.
module prim_flop_sync_chain #(
  parameter int unsigned     Width      = 1,
  parameter int unsigned     Stages     = 2,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Stages-1:0][Width-1:0] sync_q;

  // shift the input through the stages with no logic in between
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= {Stages{ResetValue}};
    else         sync_q <= {sync_q[Stages-2:0], d_i};
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/prim_debounce_filter.sv
// prim_debounce_filter: synchronise a noisy input and pass only levels that stay stable.
module prim_debounce_filter
  import prim_debounce_filter_pkg::*;
#(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned CntWidth   = 16,
  parameter logic        ResetValue = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic [CntWidth-1:0] thresh_i,
  input  logic                d_i,
  output logic                q_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic                busy_o
);

  logic                d_sync, d_prev_q, q_q, q_d, rise_q, fall_q;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  edge_t               edge_d;

  prim_flop_sync_chain #(
    .Width      (1),
    .Stages     (SyncStages),
    .ResetValue (ResetValue)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (d_i),
    .q_o    (d_sync)
  );

  // counter saturates at thresh_i; compare is live so a lowered threshold qualifies at once
  always_comb begin
    cnt_d  = (!enable_i || d_sync != d_prev_q) ? '0 :
             (cnt_q < thresh_i) ? cnt_q + 1'b1 : cnt_q;
    q_d    = (!enable_i || (d_sync == d_prev_q && cnt_q >= thresh_i)) ? d_sync : q_q;
    edge_d = edge_detect(q_q, q_d);
  end

  // filter state and registered edge pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      d_prev_q <= ResetValue;
      q_q      <= ResetValue;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      d_prev_q <= d_sync;
      q_q      <= q_d;
      rise_q   <= edge_d.rise;
      fall_q   <= edge_d.fall;
    end
  end

  assign q_o    = q_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign busy_o = d_sync ^ q_q;

endmodule
